// File: rtl/sap_core_param.sv
// Multicycle accumulator processor: FETCH/DECODE/OPERAND/HALT sequencer, four-entry
// register file, carry/zero flags and a ready-handshaked program-memory read port.
module sap_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] out,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] C,
  output logic [DATA_W-1:0] D,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_OPERAND = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;
  logic [DATA_W-1:0] r_d;
  logic [DATA_W-1:0] r_out;
  logic              r_carry;
  logic              r_zero;
  logic              r_halted;

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_operand;
  logic [1:0]        w_ridx;
  logic [DATA_W-1:0] w_regsel;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu_x;
  logic              w_sub;
  logic [DATA_W:0]   w_sum;

  // Subtraction is A + ~X + 1, so the carry out reads as "no borrow".
  function automatic logic [DATA_W:0] alu_addsub(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] x,
                                                 input logic              sub);
    logic [DATA_W-1:0] xs;
    xs = sub ? ~x : x;
    return {1'b0, a} + {1'b0, xs} + (DATA_W+1)'(sub);
  endfunction

  assign w_opcode  = r_ir[DATA_W-1 -: 4];
  assign w_operand = r_ir[ADDR_W-1:0];
  assign w_ridx    = r_ir[1:0];
  assign w_imm     = {{(DATA_W-ADDR_W){1'b0}}, w_operand};

  always_comb begin
    w_regsel = r_a;
    case (w_ridx)
      2'd0:    w_regsel = r_a;
      2'd1:    w_regsel = r_b;
      2'd2:    w_regsel = r_c;
      default: w_regsel = r_d;
    endcase
  end

  // Memory operands arrive in OPERAND, register operands are used in DECODE.
  assign w_alu_x = (r_state == S_OPERAND) ? mem_rdata : w_regsel;
  assign w_sub   = (w_opcode == 4'h3) || (w_opcode == 4'h7);
  assign w_sum   = alu_addsub(r_a, w_alu_x, w_sub);

  assign mem_rd   = !clr && ((r_state == S_FETCH) || (r_state == S_OPERAND));
  assign mem_addr = (r_state == S_OPERAND) ? w_operand : r_pc;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_out    <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_FETCH;
          case (w_opcode)
            4'h1, 4'h2, 4'h3: r_state <= S_OPERAND;
            4'h4: begin
              case (w_ridx)
                2'd1:    r_b <= r_a;
                2'd2:    r_c <= r_a;
                2'd3:    r_d <= r_a;
                default: ;
              endcase
            end
            4'h5: begin
              r_a    <= w_regsel;
              r_zero <= (w_regsel == '0);
            end
            4'h6, 4'h7: begin
              r_a     <= w_sum[DATA_W-1:0];
              r_carry <= w_sum[DATA_W];
              r_zero  <= (w_sum[DATA_W-1:0] == '0);
            end
            4'h8: begin
              r_a    <= w_imm;
              r_zero <= (w_imm == '0);
            end
            4'h9: r_pc <= w_operand;
            4'hA: if (r_carry) r_pc <= w_operand;
            4'hB: if (r_zero) r_pc <= w_operand;
            4'hE: r_out <= r_a;
            4'hF: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            default: ;
          endcase
        end
        S_OPERAND: begin
          if (mem_ready) begin
            r_state <= S_FETCH;
            if (w_opcode == 4'h1) begin
              r_a    <= mem_rdata;
              r_zero <= (mem_rdata == '0);
            end else begin
              r_a     <= w_sum[DATA_W-1:0];
              r_carry <= w_sum[DATA_W];
              r_zero  <= (w_sum[DATA_W-1:0] == '0);
            end
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign out        = r_out;
  assign A          = r_a;
  assign B          = r_b;
  assign C          = r_c;
  assign D          = r_d;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;
  assign halted     = r_halted;

endmodule
